// File: rtl/echo_pkg.sv
// echo_pkg: shared types and constants for the UART echo FIFO controller.
//   state_e       - transmit FSM state encoding
//   DEFAULT_DEPTH - default FIFO depth (entries, power of two)
//   DATA_W        - byte width carried through the FIFO
package echo_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DATA_W        = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSend     = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push     : write din this cycle; ignored when full unless pop also succeeds
//   pop      : advance the read pointer; ignored when empty
//   din      : write data
//   dout     : head entry (combinational read of the read pointer)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : current occupancy 0..DEPTH
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rptr_q];

    // A simultaneous pop frees a slot, so a push at full still succeeds.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // DEPTH is a power of two, so pointer wrap is natural overflow.
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/echo_fifo_ctrl.sv
// echo_fifo_ctrl: buffers bytes from a UART receiver and replays them to a UART transmitter.
//   clk, rst        : clock, asynchronous active-high reset
//   received        : one-cycle pulse, rx_byte valid
//   rx_byte         : received byte
//   recv_error      : one-cycle framing-error pulse
//   is_transmitting : transmitter busy
//   transmit        : one-cycle transmit request (high only in StSend)
//   tx_byte         : byte being sent, stable from request until return to idle
//   count           : FIFO occupancy
//   overflow        : sticky, set when a byte is dropped at full
//   err_count       : saturating framing-error counter
module echo_fifo_ctrl
    import echo_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              received,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              recv_error,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [DATA_W-1:0] tx_byte,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [7:0]        err_count
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DATA_W),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (received),
        .pop   (fifo_pop),
        .din   (rx_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;
        transmit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !is_transmitting) begin
                    fifo_pop  = 1'b1;
                    tx_byte_d = fifo_dout;
                    state_d   = StSend;
                end
            end
            StSend: begin
                transmit = 1'b1;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (is_transmitting) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!is_transmitting) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        overflow_d  = overflow_q | (received && fifo_full && !fifo_pop);
        err_count_d = err_count_q;
        if (recv_error && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tx_byte_q   <= '0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_echo_fifo_ctrl.sv
// tb_echo_fifo_ctrl: directed self-checking bench for echo_fifo_ctrl (DEPTH = 16).
module tb_echo_fifo_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          received;
    logic [7:0]    rx_byte;
    logic          recv_error;
    logic          is_transmitting;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    err_count;

    // Simple transmitter model: busy for 3 cycles after each request, or forced busy.
    logic          hold_busy;
    logic [2:0]    busy_cnt;
    logic [7:0]    tx_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    assign is_transmitting = hold_busy || (busy_cnt != 3'd0);

    always #5 clk = ~clk;

    echo_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .count           (count),
        .overflow        (overflow),
        .err_count       (err_count)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 3'd0;
        end else if (transmit) begin
            busy_cnt <= 3'd3;
            tx_q.push_back(tx_byte);
        end else if (busy_cnt != 3'd0) begin
            busy_cnt <= busy_cnt - 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        step();
        received = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        received   = 1'b0;
        rx_byte    = 8'h00;
        recv_error = 1'b0;
        hold_busy  = 1'b0;
        run(3);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        run(2);

        // Single byte, two-cycle latency to the request.
        push_byte(8'h41);
        check("single_count_t1", 32'(count), 32'd1);
        check("single_tx_t1", 32'(transmit), 32'd0);
        step();
        check("single_tx_t2", 32'(transmit), 32'd1);
        check("single_byte_t2", 32'(tx_byte), 32'h41);
        check("single_count_t2", 32'(count), 32'd0);
        step();
        check("single_tx_t3", 32'(transmit), 32'd0);
        run(10);
        check("single_sent_n", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("single_sent_b", 32'(tx_q[0]), 32'h41);
        tx_q.delete();

        // Five bytes queued behind a busy transmitter, sent in order.
        hold_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        run(3);
        check("five_count", 32'(count), 32'd5);
        check("five_no_tx", 32'(tx_q.size()), 32'd0);
        hold_busy = 1'b0;
        run(60);
        check("five_sent_n", 32'(tx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++)
            check($sformatf("five_b%0d", i), 32'(tx_q[i]), 32'(i + 1));
        check("five_overflow", 32'(overflow), 32'd0);
        check("five_count_end", 32'(count), 32'd0);
        tx_q.delete();

        // Error pulses: first coincides with a received byte; counter saturates.
        hold_busy  = 1'b1;
        received   = 1'b1;
        rx_byte    = 8'h77;
        recv_error = 1'b1;
        step();
        received = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("err_10", 32'(err_count), 32'd10);
        for (int i = 10; i < 300; i++) step();
        recv_error = 1'b0;
        step();
        check("err_sat", 32'(err_count), 32'd255);
        check("err_fifo_count", 32'(count), 32'd1);
        hold_busy = 1'b0;
        run(15);
        check("err_sent_n", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("err_sent_b", 32'(tx_q[0]), 32'h77);
        tx_q.delete();

        // Full FIFO with push and pop in the same cycle.
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        check("full_count", 32'(count), 32'd16);
        check("full_overflow", 32'(overflow), 32'd0);
        hold_busy = 1'b0;
        received  = 1'b1;
        rx_byte   = 8'hAA;
        step();
        received = 1'b0;
        check("pp_count", 32'(count), 32'd16);
        check("pp_overflow", 32'(overflow), 32'd0);
        run(200);
        check("pp_sent_n", 32'(tx_q.size()), 32'd17);
        for (int i = 0; i < 16 && i < tx_q.size(); i++)
            check($sformatf("pp_b%0d", i), 32'(tx_q[i]), 32'h10 + 32'(i));
        if (tx_q.size() > 16) check("pp_last", 32'(tx_q[16]), 32'hAA);
        tx_q.delete();

        // DEPTH+3 bytes with the transmitter busy: last three dropped.
        hold_busy = 1'b1;
        for (int i = 0; i < 19; i++) push_byte(8'h20 + 8'(i));
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        hold_busy = 1'b0;
        run(200);
        check("ovf_sent_n", 32'(tx_q.size()), 32'd16);
        if (tx_q.size() > 0) check("ovf_first", 32'(tx_q[0]), 32'h20);
        if (tx_q.size() > 15) check("ovf_last", 32'(tx_q[15]), 32'h2F);
        check("ovf_sticky", 32'(overflow), 32'd1);
        tx_q.delete();

        // Reset while waiting for the transmitter to finish, 4 bytes queued.
        push_byte(8'h50);
        step();
        check("mid_send", 32'(transmit), 32'd1);
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push_byte(8'h50 + 8'(i));
        run(3);
        check("mid_count", 32'(count), 32'd4);
        tx_q.delete();
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_transmit", 32'(transmit), 32'd0);
        check("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        step();
        rst = 1'b0;
        step();
        push_byte(8'h60);
        run(6);
        check("post_rst_no_tx", 32'(tx_q.size()), 32'd0);
        check("post_rst_count", 32'(count), 32'd1);
        hold_busy = 1'b0;
        run(20);
        check("post_rst_sent_n", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("post_rst_b", 32'(tx_q[0]), 32'h60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
